// File: rtl/dsp48a1_mac_sequencer.sv
// dsp48a1_mac_sequencer: drives a fully-pipelined DSP48A1 slice as a streaming
// signed 18x18 multiply-accumulator, returning one 48-bit dot product per vector.
module dsp48a1_mac_sequencer #(
    parameter int LAT      = 4,
    parameter int OPM_SKEW = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [17:0] IN_A,
    input  logic [17:0] IN_B,
    input  logic        IN_LAST,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic [47:0] RES_DATA,
    output logic [15:0] RES_COUNT,
    output logic [17:0] DSP_A,
    output logic [17:0] DSP_B,
    output logic [17:0] DSP_D,
    output logic [47:0] DSP_C,
    output logic [7:0]  DSP_OPMODE,
    output logic        DSP_CARRYIN,
    output logic        DSP_CE,
    output logic        DSP_RST,
    input  logic [47:0] DSP_P
);

    localparam logic [7:0] OPM_FIRST = 8'b0000_0001;  // P = M
    localparam logic [7:0] OPM_ACC   = 8'b0000_1001;  // P = P + M
    localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;  // P = P + 0
    localparam int         CNT_W     = $clog2(LAT + 2);
    localparam int         SR_W      = OPM_SKEW * 8;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_HOLD} state_t;

    state_t            state, state_nxt;
    logic              accept, capture;
    logic              rst_q;
    logic              slot_valid, slot_first;
    logic [17:0]       slot_a, slot_b;
    logic [7:0]        opm_issue;
    logic [SR_W-1:0]   opm_sr;
    logic [CNT_W-1:0]  drain_cnt;
    logic [15:0]       elem_cnt;

    assign IN_READY    = !rst_q && (state == S_IDLE || state == S_ACC);
    assign accept      = IN_VALID && IN_READY;
    assign RES_VALID   = (state == S_HOLD);
    assign DSP_D       = '0;
    assign DSP_C       = '0;
    assign DSP_CARRYIN = 1'b0;
    assign DSP_RST     = rst_q;
    assign DSP_CE      = !rst_q;
    assign DSP_OPMODE  = opm_sr[SR_W-1 -: 8];

    // Delayed copy of reset: drives the slice reset/CE and masks IN_READY for one cycle.
    always_ff @(posedge CLK) begin
        rst_q <= RST;
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and result-capture strobe.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = IN_LAST ? S_DRAIN : S_ACC;
            S_ACC:   if (accept && IN_LAST) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == '0) begin
                         capture   = 1'b1;
                         state_nxt = S_HOLD;
                     end
            S_HOLD:  if (RES_READY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Slot stage: register the accepted pair (or a zero bubble) and whether it opens the vector.
    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_valid <= 1'b0;
            slot_first <= 1'b0;
            slot_a     <= '0;
            slot_b     <= '0;
        end else begin
            slot_valid <= accept;
            slot_first <= (state == S_IDLE);
            slot_a     <= accept ? IN_A : '0;
            slot_b     <= accept ? IN_B : '0;
        end
    end

    // Issue stage: operands onto the slice, OPMODE enters a skew line so it meets the product at the post-adder.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DSP_A     <= '0;
            DSP_B     <= '0;
            opm_issue <= OPM_HOLD;
            opm_sr    <= {OPM_SKEW{OPM_HOLD}};
        end else begin
            DSP_A     <= slot_a;
            DSP_B     <= slot_b;
            opm_issue <= !slot_valid ? OPM_HOLD : (slot_first ? OPM_FIRST : OPM_ACC);
            opm_sr    <= (opm_sr << 8) | SR_W'(opm_issue);
        end
    end

    // Drain counter: loaded on LAST accept, counts the slice pipeline down to the capture cycle.
    always_ff @(posedge CLK) begin
        if (RST)
            drain_cnt <= '0;
        else if (accept && IN_LAST)
            drain_cnt <= CNT_W'(LAT + 1);
        else if (state == S_DRAIN && drain_cnt != '0)
            drain_cnt <= drain_cnt - 1'b1;
    end

    // Element counter: saturating count of accepted pairs, cleared as the result is consumed.
    always_ff @(posedge CLK) begin
        if (RST)
            elem_cnt <= '0;
        else if (state == S_HOLD && RES_READY)
            elem_cnt <= '0;
        else if (accept && elem_cnt != '1)
            elem_cnt <= elem_cnt + 1'b1;
    end

    // Result registers: sample the slice P output and element count at drain expiry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RES_DATA  <= '0;
            RES_COUNT <= '0;
        end else if (capture) begin
            RES_DATA  <= DSP_P;
            RES_COUNT <= elem_cnt;
        end
    end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Testbench for dsp48a1_mac_sequencer: includes a behavioural DSP48A1 slice
// model and checks results against plain dot-product arithmetic.
module tb_dsp48a1_mac_sequencer;

    localparam int LAT      = 4;
    localparam int OPM_SKEW = 2;
    localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
    localparam logic [7:0] OPM_ACC   = 8'b0000_1001;
    localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;
    localparam int RES_LAT  = LAT + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_a = '0;
    logic [17:0] in_b = '0;
    logic        in_last = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [47:0] res_data;
    logic [15:0] res_count;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [47:0] dsp_c;
    logic [7:0]  dsp_opmode;
    logic        dsp_carryin, dsp_ce, dsp_rst;
    logic [47:0] dsp_p;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    dsp48a1_mac_sequencer #(.LAT(LAT), .OPM_SKEW(OPM_SKEW)) dut (
        .CLK(clk), .RST(rst),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_A(in_a), .IN_B(in_b), .IN_LAST(in_last),
        .RES_VALID(res_valid), .RES_READY(res_ready), .RES_DATA(res_data), .RES_COUNT(res_count),
        .DSP_A(dsp_a), .DSP_B(dsp_b), .DSP_D(dsp_d), .DSP_C(dsp_c), .DSP_OPMODE(dsp_opmode),
        .DSP_CARRYIN(dsp_carryin), .DSP_CE(dsp_ce), .DSP_RST(dsp_rst), .DSP_P(dsp_p)
    );

    function automatic logic [47:0] prod48(input logic [17:0] a, input logic [17:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[47:0];
    endfunction

    // DSP48A1 slice model: A0/B0, A1/B1, M, OPMODE and P registers, Z in {0,P}, X in {0,M}.
    logic [17:0] s_a0 = '0, s_b0 = '0, s_a1 = '0, s_b1 = '0;
    logic [47:0] s_m = '0, s_p = '0;
    logic [7:0]  s_opm = '0;
    always @(posedge clk) begin
        if (dsp_rst === 1'b1) begin
            s_a0 <= '0; s_b0 <= '0; s_a1 <= '0; s_b1 <= '0;
            s_m <= '0; s_p <= '0; s_opm <= '0;
        end else if (dsp_ce === 1'b1) begin
            s_a0  <= dsp_a; s_b0 <= dsp_b;
            s_a1  <= s_a0;  s_b1 <= s_b0;
            s_m   <= prod48(s_a1, s_b1);
            s_opm <= dsp_opmode;
            s_p   <= ((s_opm[3:2] == 2'b10) ? s_p : 48'd0) + ((s_opm[1:0] == 2'b01) ? s_m : 48'd0);
        end
    end
    assign dsp_p = s_p;

    // Cycle index and per-cycle trace of slice-facing outputs (cyc = edges seen so far).
    logic [7:0]  opm_log [16384];
    logic [17:0] a_log   [16384];
    logic [17:0] b_log   [16384];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        opm_log[cyc % 16384] = dsp_opmode;
        a_log[cyc % 16384]   = dsp_a;
        b_log[cyc % 16384]   = dsp_b;
    end

    logic [17:0] vq_a[$];
    logic [17:0] vq_b[$];
    int          vq_gap[$];
    int          acc_cyc[$];

    // Feed the queued vector; vq_gap[i] bubble cycles precede element i. Records accept edges.
    task automatic drive_vector(output int last_acc, output bit to);
        int guard;
        to = 1'b0;
        last_acc = 0;
        acc_cyc.delete();
        for (int i = 0; i < vq_a.size(); i++) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
            for (int g = 0; g < vq_gap[i]; g++) @(negedge clk);
            in_valid = 1'b1;
            in_a     = vq_a[i];
            in_b     = vq_b[i];
            in_last  = (i == vq_a.size() - 1);
            guard = 0;
            while (in_ready !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                to = 1'b1;
                break;
            end
            acc_cyc.push_back(cyc + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_b     = '0;
        if (acc_cyc.size() > 0) last_acc = acc_cyc[$];
    endtask

    task automatic wait_result(input int last_acc, output int lat, output bit to);
        to  = 1'b1;
        lat = -1;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                lat = cyc - last_acc;
                to  = 1'b0;
                break;
            end
        end
    endtask

    function automatic void load_vec(input logic [17:0] a, input logic [17:0] b, input int gap);
        vq_a.push_back(a);
        vq_b.push_back(b);
        vq_gap.push_back(gap);
    endfunction

    function automatic void clear_vec();
        vq_a.delete(); vq_b.delete(); vq_gap.delete();
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        n_checks++; if (res_data !== 48'd0) begin n_fail++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
        n_checks++; if (res_count !== 16'd0) begin n_fail++; $display("FAIL reset_res_count: got %0d expected 0", res_count); end
        n_checks++; if ({dsp_a, dsp_b, dsp_d} !== 54'd0) begin n_fail++; $display("FAIL reset_dsp_abd: got %h expected 0", {dsp_a, dsp_b, dsp_d}); end
        n_checks++; if ({dsp_c, dsp_carryin} !== 49'd0) begin n_fail++; $display("FAIL reset_dsp_c_cin: got %h expected 0", {dsp_c, dsp_carryin}); end
        n_checks++; if (dsp_opmode !== OPM_HOLD) begin n_fail++; $display("FAIL reset_opmode: got %b expected %b", dsp_opmode, OPM_HOLD); end
        n_checks++; if (dsp_ce !== 1'b0) begin n_fail++; $display("FAIL reset_dsp_ce: got %b expected 0", dsp_ce); end
        n_checks++; if (dsp_rst !== 1'b1) begin n_fail++; $display("FAIL reset_dsp_rst: got %b expected 1", dsp_rst); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if ({dsp_ce, dsp_rst} !== 2'b10) begin n_fail++; $display("FAIL post_reset_ce_rst: got %b expected 10", {dsp_ce, dsp_rst}); end
    endtask

    task automatic test_dot_product();
        int last_acc, lat;
        bit to_d, to_r;
        clear_vec();
        load_vec(18'd3, 18'd4, 0);
        load_vec(18'd5, 18'd6, 0);
        load_vec(18'h3FFFE, 18'd7, 0);
        drive_vector(last_acc, to_d);
        wait_result(last_acc, lat, to_r);
        n_checks++; if ({to_d, to_r} !== 2'b00) begin n_fail++; $display("FAIL dot_timeout: got %b expected 00", {to_d, to_r}); end
        n_checks++; if (res_data !== 48'd28) begin n_fail++; $display("FAIL dot_data: got %0d expected 28", res_data); end
        n_checks++; if (res_count !== 16'd3) begin n_fail++; $display("FAIL dot_count: got %0d expected 3", res_count); end
        n_checks++; if (lat !== RES_LAT) begin n_fail++; $display("FAIL dot_latency: got %0d expected %0d", lat, RES_LAT); end
        n_checks++; if ({a_log[(acc_cyc[0] + 1) % 16384], b_log[(acc_cyc[0] + 1) % 16384]} !== {18'd3, 18'd4})
            begin n_fail++; $display("FAIL dot_operand_align: got %0d,%0d expected 3,4", a_log[(acc_cyc[0] + 1) % 16384], b_log[(acc_cyc[0] + 1) % 16384]); end
        n_checks++; if (opm_log[(acc_cyc[0] + 1 + OPM_SKEW) % 16384] !== OPM_FIRST)
            begin n_fail++; $display("FAIL dot_opm_first: got %b expected %b", opm_log[(acc_cyc[0] + 1 + OPM_SKEW) % 16384], OPM_FIRST); end
        n_checks++; if (opm_log[(acc_cyc[2] + 1 + OPM_SKEW) % 16384] !== OPM_ACC)
            begin n_fail++; $display("FAIL dot_opm_acc: got %b expected %b", opm_log[(acc_cyc[2] + 1 + OPM_SKEW) % 16384], OPM_ACC); end
        @(negedge clk);
        n_checks++; if ({res_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL dot_min_gap: got valid/ready %b expected 01", {res_valid, in_ready}); end
    endtask

    task automatic test_single();
        int last_acc, lat;
        bit to_d, to_r;
        clear_vec();
        load_vec(18'd100, 18'h3FF9C, 0);
        drive_vector(last_acc, to_d);
        wait_result(last_acc, lat, to_r);
        n_checks++; if ({to_d, to_r} !== 2'b00) begin n_fail++; $display("FAIL single_timeout: got %b expected 00", {to_d, to_r}); end
        n_checks++; if (res_data !== 48'hFFFF_FFFF_D8F0) begin n_fail++; $display("FAIL single_data: got %h expected FFFFFFFFD8F0", res_data); end
        n_checks++; if (res_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", res_count); end
        n_checks++; if (lat !== RES_LAT) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, RES_LAT); end
        n_checks++; if ({opm_log[(last_acc + 3) % 16384], opm_log[(last_acc + 4) % 16384]} !== {OPM_FIRST, OPM_HOLD})
            begin n_fail++; $display("FAIL single_opm_seq: got %b,%b expected %b,%b", opm_log[(last_acc + 3) % 16384], opm_log[(last_acc + 4) % 16384], OPM_FIRST, OPM_HOLD); end
        @(negedge clk);
    endtask

    task automatic test_bubble();
        int last_acc, lat, k;
        bit to_d, to_r;
        logic [31:0] seq, want;
        clear_vec();
        load_vec(18'd2, 18'd3, 0);
        load_vec(18'd4, 18'd5, 2);
        drive_vector(last_acc, to_d);
        wait_result(last_acc, lat, to_r);
        k = acc_cyc[0] + 1 + OPM_SKEW;
        seq  = {opm_log[k % 16384], opm_log[(k + 1) % 16384], opm_log[(k + 2) % 16384], opm_log[(k + 3) % 16384]};
        want = {OPM_FIRST, OPM_HOLD, OPM_HOLD, OPM_ACC};
        n_checks++; if ({to_d, to_r} !== 2'b00) begin n_fail++; $display("FAIL bubble_timeout: got %b expected 00", {to_d, to_r}); end
        n_checks++; if (res_data !== 48'd26) begin n_fail++; $display("FAIL bubble_data: got %0d expected 26", res_data); end
        n_checks++; if (seq !== want) begin n_fail++; $display("FAIL bubble_opm_seq: got %h expected %h", seq, want); end
        n_checks++; if (lat !== RES_LAT) begin n_fail++; $display("FAIL bubble_latency: got %0d expected %0d", lat, RES_LAT); end
        @(negedge clk);
    endtask

    task automatic test_extremes();
        int last_acc, lat;
        bit to_d, to_r;
        clear_vec();
        load_vec(18'h20000, 18'h20000, 0);
        load_vec(18'h20000, 18'h20000, 0);
        drive_vector(last_acc, to_d);
        wait_result(last_acc, lat, to_r);
        n_checks++; if ({to_d, to_r} !== 2'b00) begin n_fail++; $display("FAIL extreme_timeout: got %b expected 00", {to_d, to_r}); end
        n_checks++; if (res_data !== 48'd34359738368) begin n_fail++; $display("FAIL extreme_data: got %0d expected 34359738368", res_data); end
        n_checks++; if (res_count !== 16'd2) begin n_fail++; $display("FAIL extreme_count: got %0d expected 2", res_count); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int last_acc, lat;
        bit to_d, to_r;
        res_ready = 1'b0;
        clear_vec();
        load_vec(18'd9, 18'd10, 0);
        load_vec(18'd2, 18'd2, 1);
        drive_vector(last_acc, to_d);
        wait_result(last_acc, lat, to_r);
        n_checks++; if ({to_d, to_r} !== 2'b00) begin n_fail++; $display("FAIL bp_timeout: got %b expected 00", {to_d, to_r}); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if ({res_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_hold_flags[%0d]: got %b expected 10", i, {res_valid, in_ready}); end
            n_checks++; if ({res_data, res_count} !== {48'd94, 16'd2}) begin n_fail++; $display("FAIL bp_hold_result[%0d]: got %0d/%0d expected 94/2", i, res_data, res_count); end
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b expected 0", res_valid); end
        clear_vec();
        load_vec(18'd1, 18'd1, 0);
        drive_vector(last_acc, to_d);
        wait_result(last_acc, lat, to_r);
        n_checks++; if ({to_d, to_r} !== 2'b00) begin n_fail++; $display("FAIL bp_next_timeout: got %b expected 00", {to_d, to_r}); end
        n_checks++; if ({res_data, res_count} !== {48'd1, 16'd1}) begin n_fail++; $display("FAIL bp_next_result: got %0d/%0d expected 1/1", res_data, res_count); end
        @(negedge clk);
    endtask

    task automatic test_rst_drain();
        int last_acc, lat;
        bit to_d, to_r, seen;
        clear_vec();
        load_vec(18'd5, 18'd5, 0);
        load_vec(18'd6, 18'd6, 0);
        drive_vector(last_acc, to_d);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({res_valid, in_ready, dsp_ce, dsp_rst} !== 4'b0001) begin n_fail++; $display("FAIL rst_drain_flags: got %b expected 0001", {res_valid, in_ready, dsp_ce, dsp_rst}); end
        n_checks++; if ({dsp_opmode, dsp_a} !== {OPM_HOLD, 18'd0}) begin n_fail++; $display("FAIL rst_drain_issue: got %b/%0d expected %b/0", dsp_opmode, dsp_a, OPM_HOLD); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (dsp_rst !== 1'b0) begin n_fail++; $display("FAIL rst_drain_pulse_end: got %b expected 0", dsp_rst); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_drain_no_result: got %b expected 0", seen); end
        clear_vec();
        load_vec(18'd7, 18'd8, 0);
        drive_vector(last_acc, to_d);
        wait_result(last_acc, lat, to_r);
        n_checks++; if ({to_d, to_r} !== 2'b00) begin n_fail++; $display("FAIL rst_next_timeout: got %b expected 00", {to_d, to_r}); end
        n_checks++; if ({res_data, res_count} !== {48'd56, 16'd1}) begin n_fail++; $display("FAIL rst_next_result: got %0d/%0d expected 56/1", res_data, res_count); end
        n_checks++; if (lat !== RES_LAT) begin n_fail++; $display("FAIL rst_next_latency: got %0d expected %0d", lat, RES_LAT); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int last_acc, lat, len, d;
        bit to_d, to_r;
        logic [47:0] exp_sum;
        logic [17:0] a, b;
        for (int v = 0; v < 12; v++) begin
            clear_vec();
            exp_sum = '0;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                a = 18'($urandom);
                b = 18'($urandom);
                exp_sum = exp_sum + prod48(a, b);
                load_vec(a, b, $urandom_range(0, 2));
            end
            d = $urandom_range(0, 3);
            res_ready = (d == 0);
            drive_vector(last_acc, to_d);
            wait_result(last_acc, lat, to_r);
            n_checks++; if ({to_d, to_r} !== 2'b00) begin n_fail++; $display("FAIL rand_timeout[%0d]: got %b expected 00", v, {to_d, to_r}); end
            n_checks++; if (res_data !== exp_sum) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", v, res_data, exp_sum); end
            n_checks++; if (res_count !== 16'(len)) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", v, res_count, len); end
            n_checks++; if (lat !== RES_LAT) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", v, lat, RES_LAT); end
            repeat (d) @(negedge clk);
            res_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_dot_product();
        test_single();
        test_bubble();
        test_extremes();
        test_backpressure();
        test_rst_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
